apb_cmd_master: RTL and testbench

APB initiator that turns single-beat command requests from an internal client into APB transfers on the master side of the team's APB interface, and returns read data and completion status on a response handshake. It sits between a local controller (test sequencer, DMA, or CPU-side bridge) and APB slaves such as the dual-port memory. It issues one transfer at a time. It enforces the SETUP/ACCESS sequence and aborts stalled transfers with a programmable timeout.

---
 rtl/apb_cmd_master.sv | 142 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB initiator: accepts single-beat read/write commands from a local client,
// runs the SETUP/ACCESS sequence on APB and returns data/status on a response handshake.
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic                    timeout_hit;

  assign cmd_ready   = (state_q == IDLE) && !PRESET;
  // The N-th stalled ACCESS edge sees the counter at N-1.
  assign timeout_hit = TO_EN && (wait_cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    wait_cnt_d    = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          if (cmd_write) pwdata_d = cmd_wdata;
        end
      end
      SETUP: begin
        state_d    = ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
        end else if (timeout_hit) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: random and directed commands against a word-memory APB
// slave, with expected responses queued at command acceptance and checked by a monitor.
module tb_apb_cmd_master;
  localparam int TO = 4;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA = '0;
  logic        PWRITE, PSEL, PENABLE, PREADY = 1'b0;

  logic        c0_cmd_valid = 1'b0, c0_cmd_ready, c0_cmd_write = 1'b0;
  logic [31:0] c0_cmd_addr = '0, c0_cmd_wdata = '0;
  logic        c0_rsp_valid, c0_rsp_ready = 1'b1, c0_rsp_timeout;
  logic [31:0] c0_rsp_rdata, c0_paddr, c0_pwdata, c0_prdata = '0;
  logic        c0_pwrite, c0_psel, c0_penable, c0_pready = 1'b0;

  apb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY));

  apb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(c0_cmd_valid), .cmd_ready(c0_cmd_ready), .cmd_write(c0_cmd_write),
    .cmd_addr(c0_cmd_addr), .cmd_wdata(c0_cmd_wdata),
    .rsp_valid(c0_rsp_valid), .rsp_ready(c0_rsp_ready), .rsp_rdata(c0_rsp_rdata),
    .rsp_timeout(c0_rsp_timeout),
    .PADDR(c0_paddr), .PWRITE(c0_pwrite), .PSEL(c0_psel), .PENABLE(c0_penable),
    .PWDATA(c0_pwdata), .PRDATA(c0_prdata), .PREADY(c0_pready));

  typedef struct {
    logic [31:0] rdata;
    bit          tmo;
    int          rise;
  } exp_t;

  exp_t        sb_q[$];
  int          wait_q[$];
  logic [31:0] smem    [0:255];
  logic [31:0] ref_mem [0:255];
  int          n_chk = 0, n_err = 0, cyc = 0;
  int          bp_cycles = 0, last_acc = -1;
  bit          rnd_bp = 1'b0, chk_gap = 1'b0;

  // monitor history
  logic        pv_valid = 1'b0, pv_hs = 1'b0, pv_acc = 1'b0, pv_psel = 1'b0, pv_rst = 1'b1;
  logic        pv_tmo = 1'b0, pv_pwrite = 1'b0, pv_cw = 1'b0;
  logic [31:0] pv_rdata = '0, pv_paddr = '0, pv_pwdata = '0, pv_ca = '0, pv_cd = '0;

  initial forever #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input int wt, input bit keep);
    int          guard = 0;
    int          e_cyc;
    exp_t        e;
    logic [7:0]  ix;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (!cmd_ready && guard < 500) begin
      @(negedge PCLK);
      guard++;
    end
    if (!cmd_ready) begin
      n_chk++; n_err++;
      $display("FAIL accept_wait: cmd_ready got 0 expected 1 within 500 cycles");
      cmd_valid = 1'b0;
      return;
    end
    e_cyc = cyc + 1;
    ix = a[9:2];
    if (wt >= TO) begin
      e.rdata = '0; e.tmo = 1'b1; e.rise = e_cyc + 1 + TO;
    end else begin
      e.tmo = 1'b0; e.rise = e_cyc + 2 + wt;
      if (w) begin
        ref_mem[ix] = d;
        e.rdata = '0;
      end else begin
        e.rdata = ref_mem[ix];
      end
    end
    if (chk_gap && last_acc >= 0) chk("accept_gap", 128'(e_cyc - last_acc), 128'(4));
    last_acc = e_cyc;
    sb_q.push_back(e);
    wait_q.push_back(wt);
    @(negedge PCLK);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() != 0 && g < 300) begin
      @(negedge PCLK);
      g++;
    end
    chk("drain_pending", 128'(sb_q.size()), 128'(0));
    @(negedge PCLK);
  endtask

  // APB slave: word memory, per-transfer wait count taken from wait_q.
  initial begin
    int         acc_cnt = 0, cur_w = 0;
    logic [7:0] ix;
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE && !PRESET) begin
        if (acc_cnt == 0) begin
          cur_w = 0;
          if (wait_q.size() > 0) cur_w = wait_q.pop_front();
        end
        if (acc_cnt == cur_w) begin
          PREADY = 1'b1;
          ix = PADDR[9:2];
          if (PWRITE) begin
            smem[ix] = PWDATA;
            PRDATA = $urandom();
          end else begin
            PRDATA = smem[ix];
          end
        end else begin
          PREADY = 1'b0;
          PRDATA = $urandom();
        end
        acc_cnt++;
      end else begin
        acc_cnt = 0;
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = $urandom();
      end
    end
  end

  // Response consumer
  initial forever begin
    @(negedge PCLK);
    if (bp_cycles > 0 && rsp_valid) begin
      rsp_ready = 1'b0;
      bp_cycles--;
    end else begin
      rsp_ready = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      #1;
      if (PRESET) begin
        pv_rst = 1'b1; pv_valid = 1'b0; pv_hs = 1'b0; pv_acc = 1'b0; pv_psel = 1'b0;
      end else begin
        if (PENABLE) chk("penable_needs_psel", 128'(PSEL), 128'(1));
        if (PSEL && !pv_psel) chk("penable_first_cycle", 128'(PENABLE), 128'(0));
        chk("cmd_ready_decode", 128'(cmd_ready), 128'(!PSEL && !rsp_valid));
        if (!pv_rst) begin
          if (pv_acc)
            chk("bus_capture", 128'({PADDR, PWRITE, PWDATA}),
                128'({pv_ca, pv_cw, (pv_cw ? pv_cd : pv_pwdata)}));
          else
            chk("bus_hold", 128'({PADDR, PWRITE, PWDATA}), 128'({pv_paddr, pv_pwrite, pv_pwdata}));
        end
        if (rsp_valid && pv_valid && !pv_hs)
          chk("rsp_stable", 128'({rsp_rdata, rsp_timeout}), 128'({pv_rdata, pv_tmo}));
        if (rsp_valid && !pv_valid) begin
          if (sb_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL rsp_unexpected: rsp_valid got 1 expected 0 (cycle %0d)", cyc);
          end else begin
            chk("rsp_latency", 128'(cyc), 128'(sb_q[0].rise));
          end
        end
        if (rsp_valid && rsp_ready && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
          chk("rsp_timeout", 128'(rsp_timeout), 128'(e.tmo));
        end
        pv_valid = rsp_valid; pv_hs = rsp_valid && rsp_ready;
        pv_rdata = rsp_rdata; pv_tmo = rsp_timeout;
        pv_acc = cmd_valid && cmd_ready;
        pv_ca = cmd_addr; pv_cw = cmd_write; pv_cd = cmd_wdata;
        pv_paddr = PADDR; pv_pwrite = PWRITE; pv_pwdata = PWDATA;
        pv_psel = PSEL; pv_rst = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          r, wt, g;
    bit          w, keep;
    for (int i = 0; i < 256; i++) begin
      v = $urandom();
      smem[i] = v;
      ref_mem[i] = v;
    end
    smem[9] = 32'hA5A5_0001;
    ref_mem[9] = 32'hA5A5_0001;

    @(negedge PCLK); #1;
    chk("reset_outputs",
        128'({PSEL, PENABLE, PWRITE, rsp_valid, rsp_timeout, PADDR, PWDATA, rsp_rdata, cmd_ready}),
        128'(0));
    @(negedge PCLK); #3;
    PRESET = 1'b0;
    #1 chk("ready_after_reset", 128'(cmd_ready), 128'(1));
    @(negedge PCLK);

    // zero-wait write
    issue(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    chk("t1_setup", 128'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}),
        128'({1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF}));
    @(negedge PCLK);
    chk("t1_access", 128'({PSEL, PENABLE}), 128'(2'b11));
    @(negedge PCLK);
    chk("t1_resp", 128'({PSEL, PENABLE, rsp_valid}), 128'(3'b001));
    drain();

    // read with two wait states
    issue(1'b0, 32'h24, 32'h0, 2, 1'b0);
    drain();

    // timeout read, timed-out write, then read back the untouched word
    issue(1'b0, 32'h80, 32'h0, 9, 1'b0);
    repeat (4) @(negedge PCLK);
    chk("t3_still_access", 128'({PSEL, PENABLE, rsp_valid}), 128'(3'b110));
    @(negedge PCLK);
    chk("t3_abort", 128'({PSEL, PENABLE, rsp_valid, rsp_timeout, rsp_rdata}),
        128'({4'b0011, 32'h0}));
    drain();
    issue(1'b1, 32'h84, 32'h1111_2222, 5, 1'b0);
    issue(1'b0, 32'h84, 32'h0, 0, 1'b0);
    drain();

    // response back-pressure with a command waiting behind it
    bp_cycles = 5;
    issue(1'b0, 32'h24, 32'h0, 1, 1'b1);
    issue(1'b1, 32'h30, 32'h55AA_33CC, 0, 1'b0);
    drain();

    // back-to-back alternating write/read
    chk_gap = 1'b1; last_acc = -1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) issue(1'b1, 32'(i * 4), $urandom(), 0, 1'b1);
      else            issue(1'b0, 32'((i - 1) * 4), 32'h0, 0, 1'b1);
    end
    cmd_valid = 1'b0;
    chk_gap = 1'b0;
    drain();

    // random traffic with random back-pressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      wt = (r < 7) ? (r % 4) : (r - 3);
      keep = ($urandom_range(0, 3) == 0);
      issue(w, $urandom() & 32'hFFFF_FFFC, $urandom(), wt, keep);
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge PCLK);
    end
    cmd_valid = 1'b0;
    rnd_bp = 1'b0;
    drain();

    // reset during ACCESS wait states
    issue(1'b0, 32'h10, 32'h0, 20, 1'b0);
    @(negedge PCLK);
    @(negedge PCLK);
    #3 PRESET = 1'b1;
    #1 chk("midreset_outputs", 128'({PSEL, PENABLE, rsp_valid, cmd_ready, PADDR}), 128'(0));
    void'(sb_q.pop_back());
    @(negedge PCLK);
    @(negedge PCLK);
    #3 PRESET = 1'b0;
    #1 chk("midreset_ready", 128'(cmd_ready), 128'(1));
    @(negedge PCLK);
    issue(1'b0, 32'h10, 32'h0, 1, 1'b0);
    drain();

    // TIMEOUT_CYCLES = 0 instance: long stall completes normally
    c0_cmd_write = 1'b0; c0_cmd_addr = 32'h40; c0_cmd_valid = 1'b1;
    g = 0;
    while (!c0_cmd_ready && g < 50) begin
      @(negedge PCLK);
      g++;
    end
    @(negedge PCLK);
    c0_cmd_valid = 1'b0;
    repeat (100) @(negedge PCLK);
    chk("t0_still_waiting", 128'({c0_psel, c0_penable, c0_rsp_valid}), 128'(3'b110));
    c0_pready = 1'b1;
    c0_prdata = 32'h1234_5678;
    @(negedge PCLK);
    c0_pready = 1'b0;
    chk("t0_rsp", 128'({c0_rsp_valid, c0_rsp_timeout, c0_rsp_rdata}),
        128'({1'b1, 1'b0, 32'h1234_5678}));
    @(negedge PCLK);
    chk("t0_idle", 128'({c0_cmd_ready, c0_psel}), 128'(2'b10));

    repeat (3) @(negedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
